// File: rtl/d_mem_store_buffer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips_pkg : shared word width and store-buffer entry type
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/d_mem_store_buffer_sb_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sb_queue : circular store queue with youngest-match address search
// Rev 1.0
// ============================================================================
module sb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head_entry,
  output logic [CNT_W-1:0]  count,
  input  logic [WORD_W-1:0] search_addr,
  output logic              hit,
  output logic [WORD_W-1:0] hit_data
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + PTR_W'(1);
      if (pop)  r_head <= r_head + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: validity is carried by head/count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_tail] <= push_entry;
  end

  // Scan oldest to youngest so that the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == search_addr)) begin
        hit      = 1'b1;
        hit_data = r_mem[w_idx].data;
      end
    end
  end

  assign head_entry = r_mem[r_head];
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/d_mem_store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// d_mem_store_buffer : posted-write buffer between EX/MEM and D_MEM
// Rev 1.0
// ============================================================================
module d_mem_store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] Write_data,
  output logic [WORD_W-1:0] Read_data,
  output logic              Stall,
  output logic              Empty,
  output logic              dm_MemWrite,
  output logic              dm_MemRead,
  output logic [WORD_W-1:0] dm_Address,
  output logic [WORD_W-1:0] dm_Write_data,
  input  logic [WORD_W-1:0] dm_Read_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_count;
  sb_entry_t         w_head_entry;
  sb_entry_t         w_push_entry;
  logic              w_hit;
  logic [WORD_W-1:0] w_hit_data;
  logic              w_idle;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_full;
  logic              w_starved;
  logic              w_drain;
  logic              w_enqueue;

  // A simultaneous read/write request is treated as a load.
  assign w_idle     = !MemRead && !MemWrite;
  assign w_is_load  = MemRead;
  assign w_is_store = MemWrite && !MemRead;
  assign w_full     = (w_count == CNT_W'(DEPTH));
  assign w_starved  = (r_starve_cnt == STV_W'(STARVE_LIMIT));

  assign Stall     = (w_is_store && w_full) || (!w_idle && w_starved);
  assign w_drain   = (w_count != '0) && (w_idle || Stall);
  assign w_enqueue = w_is_store && !Stall;

  assign w_push_entry.addr = Address;
  assign w_push_entry.data = Write_data;

  sb_queue #(
    .DEPTH (DEPTH)
  ) u_sb_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_enqueue),
    .push_entry  (w_push_entry),
    .pop         (w_drain),
    .head_entry  (w_head_entry),
    .count       (w_count),
    .search_addr (Address),
    .hit         (w_hit),
    .hit_data    (w_hit_data)
  );

  // Drain and an accepted load are mutually exclusive, so one port mux suffices.
  assign dm_MemWrite   = w_drain;
  assign dm_MemRead    = w_is_load && !Stall;
  assign dm_Address    = w_drain    ? w_head_entry.addr :
                         dm_MemRead ? Address           : '0;
  assign dm_Write_data = w_drain ? w_head_entry.data : '0;
  assign Read_data     = !dm_MemRead ? '0           :
                         w_hit       ? w_hit_data   : dm_Read_data;
  assign Empty         = (w_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_drain || (w_count == '0)) begin
      r_starve_cnt <= '0;
    end else if (!w_idle && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + STV_W'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && MemRead && MemWrite)
      $display("WARNING d_mem_store_buffer: MemRead and MemWrite both set, store ignored (addr %h)", Address);
  end
`endif

endmodule
`default_nettype wire
